// File: rtl/cacheline_arbiter.sv
// Two-port line arbiter: shares one physical-memory line port between I-cache (read) and D-cache (read/write).
// Latency: request sampled at edge t, pmem op from t+1, x_resp one cycle after pmem_resp (minimum 2 cycles).
// Backpressure: requesters hold their request until x_resp; one transaction at a time, round-robin on ties.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   i_read/i_address         - I-cache line read request (held until i_resp)
//   i_rdata/i_resp           - returned line and one-cycle completion pulse to I-cache
//   d_read/d_write/d_address/d_wdata - D-cache line read or writeback request (held until d_resp)
//   d_rdata/d_resp           - returned line and one-cycle completion pulse to D-cache
//   pmem_read/pmem_write/pmem_address/pmem_wdata - registered memory request, held for the whole transaction
//   pmem_rdata/pmem_resp     - memory read data and one-cycle completion pulse
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // Byte-offset bits inside one line; cleared on the memory address.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((LINE_W / 8) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;       // 1: D-cache was granted most recently
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_resp_d       = 1'b0;
        d_resp_d       = 1'b0;

        d_req   = d_read | d_write;
        // On a tie the port that was not served last wins.
        grant_d = d_req & (~i_read | ~last_d_q);
        grant_i = i_read & (~d_req | last_d_q);

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d        = SERVE_D;
                    last_d_d       = 1'b1;
                    pmem_address_d = d_address & ~OFF_MASK;
                    // A simultaneous read+write request is executed as a writeback.
                    pmem_write_d   = d_write;
                    pmem_read_d    = ~d_write;
                    pmem_wdata_d   = d_wdata;
                end else if (grant_i) begin
                    state_d        = SERVE_I;
                    last_d_d       = 1'b0;
                    pmem_address_d = i_address & ~OFF_MASK;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d     = RESP_I;
                    i_rdata_d   = pmem_rdata;
                    i_resp_d    = 1'b1;
                    pmem_read_d = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d = RESP_D;
                    // On a writeback d_rdata keeps the last captured read line.
                    if (pmem_read_q) begin
                        d_rdata_d = pmem_rdata;
                    end
                    d_resp_d     = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            // One response cycle, then always pass through IDLE so a request
            // still held during the response cycle is never re-granted.
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_resp_q       <= i_resp_d;
            d_resp_q       <= d_resp_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: table of single transactions plus hand-written multi-cycle sequences.
// A line memory model answers pmem requests; a monitor matches pmem traffic and responses against queues.
// Requesters hold their request until resp and drop it in the following cycle.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         inj_resp;
    int           mem_lat;

    assign pmem_resp  = mem_resp | inj_resp;
    assign pmem_rdata = inj_resp ? {8{32'hDEAD_BEEF}} : mem_rdata;

    always #5 clk = ~clk;

    cacheline_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct packed {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wdata;
    } pm_t;

    typedef struct packed {
        logic         chk;
        logic [255:0] rdata;
    } rs_t;

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           lat;
        logic [31:0]  exp_addr;
        logic         exp_wr;
        logic [255:0] exp_rdata;
        logic         chk_rdata;
    } vec_t;

    pm_t exp_i_pm[$];
    pm_t exp_d_pm[$];
    rs_t exp_i_rs[$];
    rs_t exp_d_rs[$];
    int  grant_log[$];       // 0 = I, 1 = D, in pmem order
    int  checks = 0;
    int  passed = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Initial content of memory lines that were never written.
    function automatic logic [255:0] memf(input logic [31:0] a);
        return {8{a ^ 32'h9E37_79B9}};
    endfunction

    function automatic logic [299:0] pk(input logic wr, input logic rd, input logic [31:0] a,
                                         input logic [255:0] wd);
        return {10'b0, wr, rd, a, (wr ? wd : 256'b0)};
    endfunction

    // Memory model: answers after mem_lat cycles of a held request.
    initial begin : memory
        logic [255:0] mem [logic [31:0]];
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (rst || !(pmem_read || pmem_write)) begin
                cnt = 0;
            end else if (cnt < mem_lat) begin
                cnt++;
                if (cnt == mem_lat) begin
                    mem_resp = 1'b1;
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else mem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : memf(pmem_address);
                end
            end
        end
    end

    // Monitor: pmem traffic must match a queued request; responses must follow pmem_resp by one cycle.
    initial begin : monitor
        logic [299:0] act, start_act, ev;
        logic op, prev_op, in_txn, found;
        int owner, resp_owner, resp_cyc;
        pm_t e;
        rs_t r;
        prev_op = 1'b0; in_txn = 1'b0; owner = -1; resp_owner = -1; resp_cyc = -10;
        forever begin
            @(negedge clk);
            op  = pmem_read | pmem_write;
            act = pk(pmem_write, pmem_read, pmem_address, pmem_wdata);
            if (op) check("pmem_one_op", {299'b0, pmem_read & pmem_write}, 300'b0);
            if (op && !in_txn) begin
                check("pmem_idle_gap", {299'b0, prev_op}, 300'b0);
                found = 1'b0;
                ev = '0;
                if (exp_d_pm.size() > 0) begin
                    e = exp_d_pm[0];
                    ev = pk(e.wr, ~e.wr, e.addr, e.wdata);
                    if (ev === act) begin
                        found = 1'b1; owner = 1; void'(exp_d_pm.pop_front());
                    end
                end
                if (!found && exp_i_pm.size() > 0) begin
                    e = exp_i_pm[0];
                    if (pk(e.wr, ~e.wr, e.addr, e.wdata) === act || exp_d_pm.size() == 0)
                        ev = pk(e.wr, ~e.wr, e.addr, e.wdata);
                    if (ev === act) begin
                        found = 1'b1; owner = 0; void'(exp_i_pm.pop_front());
                    end
                end
                check("pmem_txn", act, ev);
                if (found) grant_log.push_back(owner);
                else owner = -1;
                start_act = act;
                in_txn = 1'b1;
            end else if (op && in_txn) begin
                check("pmem_held_stable", act, start_act);
            end
            if (op && pmem_resp) begin
                resp_cyc = cyc; resp_owner = owner; in_txn = 1'b0;
            end
            if (!op) in_txn = 1'b0;
            prev_op = op;
            if (i_resp) begin
                check("i_resp_expected", {299'b0, exp_i_rs.size() != 0}, 300'd1);
                check("i_resp_timing", cyc, resp_cyc + 1);
                check("i_resp_owner", resp_owner, 0);
                if (exp_i_rs.size() != 0) begin
                    r = exp_i_rs.pop_front();
                    if (r.chk) check("i_rdata", i_rdata, r.rdata);
                end
            end
            if (d_resp) begin
                check("d_resp_expected", {299'b0, exp_d_rs.size() != 0}, 300'd1);
                check("d_resp_timing", cyc, resp_cyc + 1);
                check("d_resp_owner", resp_owner, 1);
                if (exp_d_rs.size() != 0) begin
                    r = exp_d_rs.pop_front();
                    if (r.chk) check("d_rdata", d_rdata, r.rdata);
                end
            end
        end
    end

    task automatic i_txn(input logic [31:0] a, input logic [31:0] ea, input logic [255:0] er,
                         output int n);
        exp_i_pm.push_back('{addr: ea, wr: 1'b0, wdata: 256'b0});
        exp_i_rs.push_back('{chk: 1'b1, rdata: er});
        i_address = a;
        i_read = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!i_resp && n < 100);
        check("i_resp_seen", {299'b0, i_resp}, 300'd1);
        @(posedge clk); #1;
        i_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] wd,
                         input logic [31:0] ea, input logic ewr, input logic [255:0] er,
                         input logic chk, output int n);
        exp_d_pm.push_back('{addr: ea, wr: ewr, wdata: wd});
        exp_d_rs.push_back('{chk: chk, rdata: er});
        d_address = a;
        d_wdata = wd;
        d_read = rd;
        d_write = wr;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!d_resp && n < 100);
        check("d_resp_seen", {299'b0, d_resp}, 300'd1);
        @(posedge clk); #1;
        d_read = 1'b0;
        d_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {262'b0, i_resp, d_resp, pmem_read, pmem_write, pmem_address}, 300'b0);
        check({tag, "_pmem_wdata"}, pmem_wdata, 300'b0);
        check({tag, "_i_rdata"}, i_rdata, 300'b0);
        check({tag, "_d_rdata"}, d_rdata, 300'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[7];
        int n, ni, nd, g0;

        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0064, 256'b0, 3, 32'h0000_0060, 1'b0, memf(32'h0000_0060), 1'b1};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h1000_0020, {32{8'hA5}}, 2, 32'h1000_0020, 1'b1, 256'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h1000_003F, 256'b0, 1, 32'h1000_0020, 1'b0, {32{8'hA5}}, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h2000_0044, 256'b0, 1, 32'h2000_0040, 1'b0, memf(32'h2000_0040), 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 32'h2000_0047, {32{8'h5A}}, 4, 32'h2000_0040, 1'b1, 256'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h2000_0040, 256'b0, 3, 32'h2000_0040, 1'b0, {32{8'h5A}}, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 256'b0, 2, 32'hFFFF_FFE0, 1'b0, memf(32'hFFFF_FFE0), 1'b1};

        rst = 1'b1; inj_resp = 1'b0; mem_lat = 1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single transactions: request-to-resp is memory latency plus one cycle of the SERVE entry.
        for (int k = 0; k < 7; k++) begin
            mem_lat = vt[k].lat;
            if (vt[k].is_d)
                d_txn(vt[k].rd, vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].exp_addr, vt[k].exp_wr,
                      vt[k].exp_rdata, vt[k].chk_rdata, n);
            else
                i_txn(vt[k].addr, vt[k].exp_addr, vt[k].exp_rdata, n);
            check("resp_latency", n, vt[k].lat + 1);
        end

        // I address changes while SERVE_I is in progress: latched address must be kept.
        mem_lat = 4;
        exp_i_pm.push_back('{addr: 32'h0000_4000, wr: 1'b0, wdata: 256'b0});
        exp_i_rs.push_back('{chk: 1'b1, rdata: memf(32'h0000_4000)});
        i_address = 32'h0000_4004;
        i_read = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        i_address = 32'h0000_8008;
        @(posedge clk); #1;
        check("latched_addr", pmem_address, 300'h0000_4000);
        n = 0;
        while (!i_resp && n < 100) begin @(posedge clk); #1; n++; end
        check("mid_change_resp_seen", {299'b0, i_resp}, 300'd1);
        @(posedge clk); #1;
        i_read = 1'b0;
        @(posedge clk); #1;

        // d_read and d_write together execute as a writeback; an I read then sees the written line.
        mem_lat = 2;
        d_txn(1'b1, 1'b1, 32'h6000_0013, {32{8'hC3}}, 32'h6000_0000, 1'b1, 256'b0, 1'b0, n);
        i_txn(32'h6000_0000, 32'h6000_0000, {32{8'hC3}}, n);

        // Reset while pmem_read is high: abandoned transaction, late pmem_resp ignored.
        mem_lat = 6;
        exp_i_pm.push_back('{addr: 32'h7000_0000, wr: 1'b0, wdata: 256'b0});
        i_address = 32'h7000_0004;
        i_read = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("pmem_read_before_rst", {299'b0, pmem_read}, 300'd1);
        rst = 1'b1;
        i_read = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        inj_resp = 1'b1;
        @(posedge clk); #1;
        inj_resp = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("late_resp_ignored", {255'b0, i_resp, d_resp, i_rdata[31:0], 12'b0}, 300'b0);
        mem_lat = 2;
        i_txn(32'h7000_0040, 32'h7000_0040, memf(32'h7000_0040), n);
        check("post_rst_latency", n, 3);

        // Continuous contention from a common start cycle: D first (last grant was I), then strict alternation.
        mem_lat = 2;
        g0 = grant_log.size();
        fork
            begin
                for (int k = 0; k < 4; k++)
                    i_txn(32'h5000_0001 + 32'(k * 32), 32'h5000_0000 + 32'(k * 32),
                          memf(32'h5000_0000 + 32'(k * 32)), ni);
            end
            begin
                for (int k = 0; k < 4; k++)
                    d_txn(k % 2 == 0, k % 2 == 1, 32'h5800_0003 + 32'(k * 32),
                          {8{32'h1111_0000 + 32'(k)}}, 32'h5800_0000 + 32'(k * 32), k % 2 == 1,
                          memf(32'h5800_0000 + 32'(k * 32)), k % 2 == 0, nd);
            end
        join
        check("grant_count", grant_log.size() - g0, 8);
        for (int j = 0; j < 8; j++) begin
            if (g0 + j < grant_log.size())
                check("grant_order", grant_log[g0 + j], (j % 2 == 0) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_i_resp", exp_i_rs.size(), 0);
        check("pending_d_resp", exp_d_rs.size(), 0);
        check("pending_pmem", exp_i_pm.size() + exp_d_pm.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
